ro_puf_ctrl: RTL and testbench
==============================

Name: ro_puf_ctrl

Overview:
- Parametrised controller for an array of N feedback ring oscillators, which are instantiated outside this block.
- Per challenge it enables one oscillator pair and counts each oscillator's rising edges over a fixed clk window. It compares the two counts and returns one response bit plus the raw counts.
- Successor to the single free-running oscillator: adds gated per-RO enables, measurement, saturation and a start/done handshake.
- Sits between the RO array and the PUF/TRNG readout logic.

Parameters:
- N_RO, 8, number of ring oscillators; must be ≥2.
- SEL_W, $clog2(N_RO), width of each challenge index.
- CNT_W, 16, edge-counter width.
- WINDOW, 1024, measurement length in clk cycles; must be ≥1.
- SETTLE, 4, clk cycles between enabling the ROs and starting to count; 0 is allowed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- chal_a  in  SEL_W  index of oscillator A; sampled when start is accepted.
- chal_b  in  SEL_W  index of oscillator B; sampled when start is accepted.
- ro_out  in  N_RO  raw oscillator outputs, asynchronous to clk.
- ro_en  out  N_RO  per-oscillator enable; one-hot-pair while measuring.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse when the result is valid.
- resp  out  1  response bit, 1 when cnt_a > cnt_b.
- tie  out  1  cnt_a == cnt_b.
- err  out  1  invalid challenge: chal_a == chal_b, or an index ≥ N_RO.
- cnt_a  out  CNT_W  final edge count of oscillator A.
- cnt_b  out  CNT_W  final edge count of oscillator B.

Behaviour:
- Reset and clocking
  - Reset is synchronous, active-low, clk only.
  - On reset all outputs go to 0, the FSM goes to IDLE, and counters and synchronisers clear.
  - Reset mid-measurement aborts at the next edge: ro_en drops, no done pulse is issued, previous results are cleared.
- Input synchronisation
  - Each ro_out bit passes through a 2-flop synchroniser followed by a rising-edge detector (sync2 & ~sync3).
  - Only the two selected bits are counted.
  - RO frequency must be < clk/2; faster oscillators undercount, which is accepted and not flagged.
- FSM states: IDLE, SETTLE, COUNT, CMP, DONE.
  - IDLE, start=1:
    - Latch chal_a/chal_b and clear both counters.
    - If the challenge is invalid, go directly to DONE with err=1, resp=0, tie=0, counts 0. No oscillator is enabled.
    - Otherwise set ro_en[chal_a] and ro_en[chal_b], assert busy, go to SETTLE.
  - SETTLE: wait SETTLE cycles with counters held at 0, then go to COUNT. When SETTLE=0, go straight to COUNT.
  - COUNT:
    - Runs exactly WINDOW cycles, tracked by a window counter.
    - Each counter increments on its edge detect and saturates at 2^CNT_W−1; no wrap.
    - On the last window cycle, ro_en returns to all-0 on the next edge and the FSM goes to CMP.
  - CMP: one cycle. Register resp = (cnt_a > cnt_b) and tie = (cnt_a == cnt_b); a tie forces resp=0. Update cnt_a/cnt_b outputs.
  - DONE: done=1 for one cycle, busy drops in the same cycle, then return to IDLE.
- Result timing
  - Latency from start to done is SETTLE + WINDOW + 2 cycles for a valid challenge.
  - Latency is 1 cycle for an invalid challenge.
- Result outputs (resp, tie, err, cnt_a, cnt_b)
  - Hold until the next accepted start.
  - On the next accepted start, err clears.
- Handshake rules
  - start while busy=1 is ignored, with no queueing.
  - start in the same cycle as done is ignored.
  - chal_* are don't-care except in the accept cycle.
- Enables: ro_en is never nonzero outside SETTLE/COUNT.

Test Plan:
- N_RO=8, WINDOW=100, SETTLE=4; RO3 at clk/4 and RO5 at clk/6; chal_a=3, chal_b=5 → ro_en=8'h28 during measurement; cnt_a=25±1, cnt_b=17±1, resp=1, tie=0; done exactly 106 cycles after start.
- Same frequencies with chal_a=5, chal_b=3 → resp=0, counts swapped; equal frequencies on both → tie=1, resp=0.
- chal_a=chal_b=2 → err=1 and done on the next cycle; ro_en stays 0; busy never asserted. Index 9 on a 16-bit-capable SEL_W configuration behaves the same way.
- CNT_W=4, WINDOW=100, RO at clk/4 → cnt saturates at 15 with no wrap; the other RO stopped (0 edges) → resp=1.
- Start pulsed again at cycle 10 of COUNT → ignored, and the result is identical to the single-start run; rst_n=0 at cycle 50 of COUNT → next cycle: ro_en=0, busy=0, no done, outputs cleared; a subsequent start runs normally.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: gates a ring-oscillator pair, counts synchronised edges over a fixed window and compares them
module ro_puf_ctrl #(
    parameter int N_RO   = 8,
    parameter int SEL_W  = $clog2(N_RO),
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    input  logic [N_RO-1:0]  ro_out,
    output logic [N_RO-1:0]  ro_en,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_settle = 3'd1;
    localparam logic [2:0] st_count  = 3'd2;
    localparam logic [2:0] st_cmp    = 3'd3;
    localparam logic [2:0] st_done   = 3'd4;
    localparam int TW = $clog2((WINDOW > SETTLE ? WINDOW : SETTLE) + 1);
    localparam logic [SEL_W:0]   n_ro        = (SEL_W + 1)'(N_RO);
    localparam logic [CNT_W-1:0] cnt_max     = '1;
    localparam logic [TW-1:0]    settle_last = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    window_last = TW'(WINDOW - 1);

    logic [2:0]       state;
    logic [N_RO-1:0]  sync1, sync2, sync3, rise, pair;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic [CNT_W-1:0] acc_a, acc_b;
    logic [TW-1:0]    tmr;
    logic             hit_a, hit_b, valid;

    always_comb begin
        rise  = sync2 & ~sync3;
        hit_a = |(rise & (N_RO'(1) << sel_a));
        hit_b = |(rise & (N_RO'(1) << sel_b));
        pair  = (N_RO'(1) << chal_a) | (N_RO'(1) << chal_b);
        valid = chal_a != chal_b && {1'b0, chal_a} < n_ro && {1'b0, chal_b} < n_ro;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= st_idle;
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            sel_a <= '0;
            sel_b <= '0;
            acc_a <= '0;
            acc_b <= '0;
            tmr   <= '0;
            ro_en <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            resp  <= 1'b0;
            tie   <= 1'b0;
            err   <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            sync1 <= ro_out;
            sync2 <= sync1;
            sync3 <= sync2;
            done  <= 1'b0;
            case (state)
                st_idle: if (start) begin
                    sel_a <= chal_a;
                    sel_b <= chal_b;
                    acc_a <= '0;
                    acc_b <= '0;
                    tmr   <= '0;
                    err   <= !valid;
                    if (valid) begin
                        ro_en <= pair;
                        busy  <= 1'b1;
                        state <= SETTLE == 0 ? st_count : st_settle;
                    end else begin
                        resp  <= 1'b0;
                        tie   <= 1'b0;
                        cnt_a <= '0;
                        cnt_b <= '0;
                        done  <= 1'b1;
                        state <= st_done;
                    end
                end
                st_settle: begin
                    tmr   <= tmr == settle_last ? '0 : tmr + 1'b1;
                    state <= tmr == settle_last ? st_count : st_settle;
                end
                st_count: begin
                    tmr <= tmr + 1'b1;
                    if (hit_a && acc_a != cnt_max) acc_a <= acc_a + 1'b1;
                    if (hit_b && acc_b != cnt_max) acc_b <= acc_b + 1'b1;
                    if (tmr == window_last) begin
                        ro_en <= '0;
                        state <= st_cmp;
                    end
                end
                st_cmp: begin
                    cnt_a <= acc_a;
                    cnt_b <= acc_b;
                    resp  <= acc_a > acc_b;
                    tie   <= acc_a == acc_b;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= st_done;
                end
                default: state <= st_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: vector table, random challenges vs. an edge-count model, and handshake/reset corner cases
module tb_ro_puf_ctrl;
    logic clk = 0, rst_n = 0, start = 0, start2 = 0;
    logic [3:0] chal_a = 0, chal_b = 0;
    logic [2:0] chal_a2 = 0, chal_b2 = 0;
    logic [7:0] ro_out = 0, ro_en, ro_en2;
    logic busy, done, resp, tie, err, busy2, done2, resp2, tie2, err2;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0] cnt_a2, cnt_b2;
    int total = 0, bad = 0, cyc = 0;
    int per[8];

    typedef struct {
        logic [3:0] a, b;
        int pa, pb;
        logic e_err, e_resp, e_tie;
        int e_lat;
    } vec_t;
    vec_t tbl[8];

    ro_puf_ctrl #(.N_RO(8), .SEL_W(4), .CNT_W(16), .WINDOW(100), .SETTLE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chal_a(chal_a), .chal_b(chal_b),
        .ro_out(ro_out), .ro_en(ro_en), .busy(busy), .done(done), .resp(resp),
        .tie(tie), .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b));

    ro_puf_ctrl #(.N_RO(8), .CNT_W(4), .WINDOW(100), .SETTLE(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .chal_a(chal_a2), .chal_b(chal_b2),
        .ro_out(ro_out), .ro_en(ro_en2), .busy(busy2), .done(done2), .resp(resp2),
        .tie(tie2), .err(err2), .cnt_a(cnt_a2), .cnt_b(cnt_b2));

    always #5 clk = ~clk;

    // Each RO has a period of per[i] clk cycles on a common time base; equal periods give identical waves
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 8; i++)
            ro_out[i] = per[i] != 0 && (cyc % per[i]) < per[i] / 2;
    end

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic run(input logic [3:0] a, b, input int pa, pb,
                       input logic e_err, rchk, e_resp, e_tie, input int e_lat);
        logic [7:0] mask;
        int lat, lo_a, hi_a, lo_b, hi_b;
        bit enbad;
        if (!a[3]) per[a[2:0]] = pa;
        if (!b[3]) per[b[2:0]] = pb;
        mask = e_err ? 8'h0 : (8'h1 << a[2:0]) | (8'h1 << b[2:0]);
        @(negedge clk);
        start = 1; chal_a = a; chal_b = b;
        lat = 0; enbad = 0;
        do begin
            @(negedge clk);
            start = 0; chal_a = 4'($urandom); chal_b = 4'($urandom);
            lat++;
            if (lat == 1 && !e_err) chk("err_clr", err, 0, 0);
            if (!done && (ro_en !== (lat < e_lat - 1 ? mask : 8'h0) || busy !== !e_err)) enbad = 1;
        end while (!done && lat < 300);
        chk("latency", lat, e_lat, e_lat);
        chk("enables", enbad, 0, 0);
        chk("done_idle", {busy, |ro_en}, 0, 0);
        repeat (2) @(negedge clk);
        lo_a = e_err ? 0 : 100 / pa; hi_a = e_err ? 0 : (100 + pa - 1) / pa;
        lo_b = e_err ? 0 : 100 / pb; hi_b = e_err ? 0 : (100 + pb - 1) / pb;
        chk("err", err, e_err, e_err);
        if (rchk) begin
            chk("resp", resp, e_resp, e_resp);
            chk("tie", tie, e_tie, e_tie);
        end
        chk("cnt_a", cnt_a, lo_a, hi_a);
        chk("cnt_b", cnt_b, lo_b, hi_b);
    endtask

    initial begin
        int lat, n;
        for (int i = 0; i < 8; i++) per[i] = 7;
        tbl[0] = '{4'd3, 4'd5, 4, 6, 1'b0, 1'b1, 1'b0, 106};
        tbl[1] = '{4'd5, 4'd3, 6, 4, 1'b0, 1'b0, 1'b0, 106};
        tbl[2] = '{4'd1, 4'd6, 5, 5, 1'b0, 1'b0, 1'b1, 106};
        tbl[3] = '{4'd2, 4'd2, 5, 5, 1'b1, 1'b0, 1'b0, 1};
        tbl[4] = '{4'd9, 4'd0, 4, 4, 1'b1, 1'b0, 1'b0, 1};
        tbl[5] = '{4'd0, 4'd7, 3, 10, 1'b0, 1'b1, 1'b0, 106};
        tbl[6] = '{4'd7, 4'd0, 12, 3, 1'b0, 1'b0, 1'b0, 106};
        tbl[7] = '{4'd4, 4'd8, 4, 4, 1'b1, 1'b0, 1'b0, 1};

        repeat (3) @(negedge clk);
        chk("reset", {ro_en, busy, done, resp, tie, err, cnt_a, cnt_b}, 0, 0);
        chk("reset_sat", {ro_en2, busy2, done2, resp2, tie2, err2, cnt_a2, cnt_b2}, 0, 0);
        rst_n = 1;

        for (int i = 0; i < 8; i++)
            run(tbl[i].a, tbl[i].b, tbl[i].pa, tbl[i].pb, tbl[i].e_err, 1'b1,
                tbl[i].e_resp, tbl[i].e_tie, tbl[i].e_lat);

        // Model: a period-P oscillator shows floor or ceil of 100/P rising edges in the window
        for (int k = 0; k < 12; k++) begin
            logic [3:0] a, b;
            int pa, pb;
            logic e_err, rchk, e_resp, e_tie;
            a = 4'($urandom_range(0, 9)); b = 4'($urandom_range(0, 9));
            pa = $urandom_range(3, 12); pb = $urandom_range(3, 12);
            e_err = a == b || a > 7 || b > 7;
            rchk = 1; e_resp = 0; e_tie = 0;
            if (!e_err && pa == pb) e_tie = 1;
            else if (!e_err && (100 + pb - 1) / pb < 100 / pa) e_resp = 1;
            else if (!e_err && !((100 + pa - 1) / pa < 100 / pb)) rchk = 0;
            run(a, b, pa, pb, e_err, rchk, e_resp, e_tie, e_err ? 1 : 106);
        end

        // Saturation on the narrow-counter instance, second RO stopped
        per[3] = 4; per[5] = 0;
        @(negedge clk);
        start2 = 1; chal_a2 = 3; chal_b2 = 5;
        lat = 0;
        do begin
            @(negedge clk);
            start2 = 0;
            lat++;
        end while (!done2 && lat < 300);
        chk("sat_latency", lat, 102, 102);
        @(negedge clk);
        chk("sat_cnt_a", cnt_a2, 15, 15);
        chk("sat_cnt_b", cnt_b2, 0, 0);
        chk("sat_resp", resp2, 1, 1);
        chk("sat_tie", tie2, 0, 0);

        // Second start in COUNT cycle 10 and a start coinciding with done are both ignored
        per[5] = 6;
        @(negedge clk);
        start = 1; chal_a = 3; chal_b = 5;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = lat == 14; chal_a = 1; chal_b = 2;
        end while (!done && lat < 300);
        chk("dbl_latency", lat, 106, 106);
        start = 1; chal_a = 0; chal_b = 1;
        @(negedge clk);
        start = 0;
        chk("start_at_done", {busy, |ro_en, done}, 0, 0);
        chk("dbl_cnt_a", cnt_a, 25, 25);
        chk("dbl_cnt_b", cnt_b, 16, 17);
        chk("dbl_resp", resp, 1, 1);

        // Reset in COUNT cycle 50 aborts without a done pulse and clears results
        @(negedge clk);
        start = 1; chal_a = 3; chal_b = 5;
        lat = 0;
        do begin
            @(negedge clk);
            start = 0;
            lat++;
        end while (lat < 54);
        rst_n = 0;
        @(negedge clk);
        chk("rst_abort", {ro_en, busy, done, resp, tie, err, cnt_a, cnt_b}, 0, 0);
        @(negedge clk);
        rst_n = 1;
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("no_done", n, 0, 0);
        run(4'd3, 4'd5, 4, 6, 1'b0, 1'b1, 1'b1, 1'b0, 106);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
